// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_RESET_DEFAULT = 32'h1c00_0000;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    // Instruction slot handed to ID.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic            adef;
    } if_slot_t;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_cancel_ctr.sv
// Saturating outstanding-request counter plus cancel counter; flags responses to be discarded.
module if_cancel_ctr #(
    parameter int unsigned  MAX_OUTST = 2,
    localparam int unsigned CW        = $clog2(MAX_OUTST + 1)
) (
    input  logic          aclk,
    input  logic          resetn,
    input  logic          acc,
    input  logic          ret,
    input  logic          redirect,
    output logic [CW-1:0] outst,
    output logic [CW-1:0] cancel_cnt,
    output logic [CW-1:0] outst_next_c,
    output logic          discard_c,
    output logic          full_c
);

    logic [CW-1:0] cancel_n;

    always_comb begin
        outst_next_c = outst;
        cancel_n     = cancel_cnt;
        full_c       = outst == CW'(MAX_OUTST);
        discard_c    = ret && (cancel_cnt != '0);
        if (acc && !ret && !full_c) begin
            outst_next_c = outst + CW'(1);
        end else if (!acc && ret && (outst != '0)) begin
            outst_next_c = outst - CW'(1);
        end
        // On redirect every request still in flight becomes wrong-path.
        if (redirect) begin
            cancel_n = outst_next_c;
        end else if (discard_c) begin
            cancel_n = cancel_cnt - CW'(1);
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            outst      <= '0;
            cancel_cnt <= '0;
        end else begin
            outst      <= outst_next_c;
            cancel_cnt <= cancel_n;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, sram-like instruction bus requests and the slot held for ID.
// Define IF_PREFETCH_EN to add a one-word prefetch buffer filled while the slot is held.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0]  PC_RESET  = PC_RESET_DEFAULT,
    parameter int unsigned  MAX_OUTST = 2
) (
    input  logic        aclk,
    input  logic        resetn,
    input  logic        if_flush,
    input  logic [31:0] flush_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        brstall,
    input  logic        id_allow_in,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_allow_in,
    output logic        if_ready_go,
    output logic        if_valid_out,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adef,
    output logic        error_inst_in_if
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    if_state_e     state, state_n;
    logic [31:0]   pc, pc_n;
    if_slot_t      slot_q, slot_n;
    logic          err_q, err_n;
    logic          req_en;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          misaligned;
    logic          fetch_en;
    logic          acc;
    logic          live;

    logic [CW-1:0] outst;
    logic [CW-1:0] cancel_cnt;
    logic [CW-1:0] outst_next_c;
    logic          discard_c;
    logic          full_c;

`ifdef IF_PREFETCH_EN
    logic          pf_valid, pf_valid_n;
    logic          pf_pend, pf_pend_n;
    logic [31:0]   pf_inst, pf_inst_n;
    logic          adv;
    logic          hold_issue;
`endif

    assign redirect    = if_flush || br_taken;
    assign redirect_pc = if_flush ? flush_pc : br_target;
    assign misaligned  = pc_misaligned(pc);
    assign fetch_en    = req_en && !brstall;
    assign acc         = inst_req && inst_addr_ok;
    // A response is live only if something is outstanding and it is not wrong-path.
    assign live        = inst_data_ok && (outst != '0) && !discard_c;

    if_cancel_ctr #(
        .MAX_OUTST (MAX_OUTST)
    ) u_cancel_ctr (
        .aclk         (aclk),
        .resetn       (resetn),
        .acc          (acc),
        .ret          (inst_data_ok),
        .redirect     (redirect),
        .outst        (outst),
        .cancel_cnt   (cancel_cnt),
        .outst_next_c (outst_next_c),
        .discard_c    (discard_c),
        .full_c       (full_c)
    );

    // Bus request and address.
`ifdef IF_PREFETCH_EN
    always_comb begin
        adv        = id_allow_in && (pf_valid || live);
        hold_issue = (state == IF_HOLD) && !slot_q.adef && (adv || (!pf_valid && !pf_pend));
        inst_req   = !full_c && (((state == IF_REQ) && fetch_en && !misaligned) || hold_issue);
        inst_addr  = pc;
        if (state == IF_HOLD) begin
            inst_addr = adv ? (pc + 32'd8) : (pc + 32'd4);
        end
    end
`else
    always_comb begin
        inst_req  = (state == IF_REQ) && fetch_en && !misaligned && !full_c;
        inst_addr = pc;
    end
`endif

    // Next-state and slot update.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        slot_n  = slot_q;
        err_n   = err_q;
`ifdef IF_PREFETCH_EN
        pf_valid_n = pf_valid;
        pf_pend_n  = pf_pend;
        pf_inst_n  = pf_inst;
`endif
        unique case (state)
            IF_REQ: begin
                if (fetch_en) begin
                    if (misaligned) begin
                        state_n     = IF_HOLD;
                        slot_n.adef = 1'b1;
                        slot_n.inst = '0;
                    end else if (acc) begin
                        state_n = IF_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                if (live) begin
                    state_n     = IF_HOLD;
                    slot_n.inst = inst_rdata;
                    slot_n.adef = 1'b0;
                end
            end
            IF_HOLD: begin
`ifdef IF_PREFETCH_EN
                pf_pend_n = acc ? 1'b1 : (live ? 1'b0 : pf_pend);
                if (id_allow_in) begin
                    pc_n = pc + 32'd4;
                    if (pf_valid) begin
                        slot_n.inst = pf_inst;
                        slot_n.adef = 1'b0;
                        pf_valid_n  = 1'b0;
                    end else if (live) begin
                        slot_n.inst = inst_rdata;
                        slot_n.adef = 1'b0;
                    end else begin
                        // Outstanding prefetch becomes the demand fetch for the new pc.
                        state_n   = pf_pend ? IF_WAIT : IF_REQ;
                        pf_pend_n = 1'b0;
                    end
                end else if (live) begin
                    pf_valid_n = 1'b1;
                    pf_inst_n  = inst_rdata;
                end
`else
                if (id_allow_in) begin
                    pc_n    = pc + 32'd4;
                    state_n = IF_REQ;
                end
`endif
            end
            default: state_n = IF_REQ;
        endcase

        if (redirect) begin
            state_n     = IF_REQ;
            pc_n        = redirect_pc;
            slot_n.inst = slot_q.inst;
            slot_n.adef = 1'b0;
`ifdef IF_PREFETCH_EN
            pf_valid_n = 1'b0;
            pf_pend_n  = 1'b0;
`endif
        end

        // Wrong-path marker: set when a taken branch leaves a word in flight with no valid slot.
        if (if_flush) begin
            err_n = 1'b0;
        end else if (br_taken) begin
            err_n = (state != IF_HOLD) && (outst_next_c != '0);
        end else if (discard_c && (cancel_cnt == CW'(1))) begin
            err_n = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state  <= IF_REQ;
            pc     <= PC_RESET;
            slot_q <= '0;
            err_q  <= 1'b0;
            req_en <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            slot_q <= slot_n;
            err_q  <= err_n;
            req_en <= 1'b1;
        end
    end

`ifdef IF_PREFETCH_EN
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            pf_valid <= 1'b0;
            pf_pend  <= 1'b0;
            pf_inst  <= '0;
        end else begin
            pf_valid <= pf_valid_n;
            pf_pend  <= pf_pend_n;
            pf_inst  <= pf_inst_n;
        end
    end
`endif

    assign if_ready_go      = (state == IF_HOLD);
    // The slot is valid exactly while it is held.
    assign if_valid_out     = if_ready_go;
    assign if_allow_in      = req_en && ((state == IF_REQ) || ((state == IF_HOLD) && id_allow_in));
    assign if_pc            = pc;
    assign if_inst          = slot_q.inst;
    assign if_adef          = slot_q.adef;
    assign error_inst_in_if = err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, fetch, branch/flush cancellation, ADEF, brstall, async reset.
module tb_if_fetch_stage;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        if_flush;
    logic [31:0] flush_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        brstall;
    logic        id_allow_in;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_allow_in;
    logic        if_ready_go;
    logic        if_valid_out;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adef;
    logic        error_inst_in_if;

    int checks   = 0;
    int failures = 0;

    if_fetch_stage dut (
        .aclk             (aclk),
        .resetn           (resetn),
        .if_flush         (if_flush),
        .flush_pc         (flush_pc),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .brstall          (brstall),
        .id_allow_in      (id_allow_in),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_addr_ok     (inst_addr_ok),
        .inst_data_ok     (inst_data_ok),
        .inst_rdata       (inst_rdata),
        .if_allow_in      (if_allow_in),
        .if_ready_go      (if_ready_go),
        .if_valid_out     (if_valid_out),
        .if_pc            (if_pc),
        .if_inst          (if_inst),
        .if_adef          (if_adef),
        .error_inst_in_if (error_inst_in_if)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        if_flush     = 1'b0;
        flush_pc     = '0;
        br_taken     = 1'b0;
        br_target    = '0;
        brstall      = 1'b0;
        id_allow_in  = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        repeat (2) step();

        // Reset state
        chk("rst_inst_req", 32'(inst_req), 32'd0);
        chk("rst_pc", if_pc, 32'h1c00_0000);
        chk("rst_valid_out", 32'(if_valid_out), 32'd0);
        chk("rst_ready_go", 32'(if_ready_go), 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        chk("rst_adef", 32'(if_adef), 32'd0);
        chk("rst_err", 32'(error_inst_in_if), 32'd0);

        // 1: release reset, zero-wait bus
        resetn       = 1'b1;
        inst_addr_ok = 1'b1;
        #1;
        chk("t1_no_req_cycle0", 32'(inst_req), 32'd0);
        step();
        chk("t1_req", 32'(inst_req), 32'd1);
        chk("t1_addr", inst_addr, 32'h1c00_0000);
        step();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0280_0421;
        #1;
        chk("t1_wait_no_req", 32'(inst_req), 32'd0);
        step();
        inst_data_ok = 1'b0;
        chk("t1_ready_go", 32'(if_ready_go), 32'd1);
        chk("t1_valid_out", 32'(if_valid_out), 32'd1);
        chk("t1_pc", if_pc, 32'h1c00_0000);
        chk("t1_inst", if_inst, 32'h0280_0421);
        id_allow_in = 1'b1;
        #1;
        chk("t1_allow_in", 32'(if_allow_in), 32'd1);
        step();
        id_allow_in = 1'b0;
        #1;
        chk("t1_next_req", 32'(inst_req), 32'd1);
        chk("t1_next_addr", inst_addr, 32'h1c00_0004);

        // 2: branch taken while awaiting the wrong-path word
        step();
        inst_addr_ok = 1'b0;
        br_taken     = 1'b1;
        br_target    = 32'h1c00_0100;
        step();
        br_taken = 1'b0;
        #1;
        chk("t2_req_target", 32'(inst_req), 32'd1);
        chk("t2_addr_target", inst_addr, 32'h1c00_0100);
        chk("t2_err_set", 32'(error_inst_in_if), 32'd1);
        chk("t2_no_ready", 32'(if_ready_go), 32'd0);
        step();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hdead_beef;
        #1;
        chk("t2_err_hold", 32'(error_inst_in_if), 32'd1);
        step();
        inst_data_ok = 1'b0;
        #1;
        chk("t2_err_clear", 32'(error_inst_in_if), 32'd0);
        chk("t2_word_dropped", if_inst, 32'h0280_0421);
        chk("t2_req_still", 32'(inst_req), 32'd1);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0015_0004;
        step();
        inst_data_ok = 1'b0;
        chk("t2_pc", if_pc, 32'h1c00_0100);
        chk("t2_inst", if_inst, 32'h0015_0004);
        chk("t2_valid", 32'(if_valid_out), 32'd1);
        id_allow_in = 1'b1;
        step();
        id_allow_in = 1'b0;
        #1;
        chk("t2_seq_addr", inst_addr, 32'h1c00_0104);

        // 3: flush coincident with data_ok
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hbadc_0de0;
        if_flush     = 1'b1;
        flush_pc     = 32'h1c00_0200;
        step();
        if_flush     = 1'b0;
        inst_data_ok = 1'b0;
        #1;
        chk("t3_req", 32'(inst_req), 32'd1);
        chk("t3_addr", inst_addr, 32'h1c00_0200);
        chk("t3_inst_kept", if_inst, 32'h0015_0004);
        chk("t3_no_ready", 32'(if_ready_go), 32'd0);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h02bf_fc0c;
        step();
        inst_data_ok = 1'b0;
        chk("t3_first_resp_live", if_inst, 32'h02bf_fc0c);
        chk("t3_pc", if_pc, 32'h1c00_0200);

        // 4: misaligned branch target -> ADEF slot
        br_taken    = 1'b1;
        br_target   = 32'h1c00_0102;
        id_allow_in = 1'b1;
        step();
        br_taken    = 1'b0;
        id_allow_in = 1'b0;
        #1;
        chk("t4_no_req", 32'(inst_req), 32'd0);
        chk("t4_no_err", 32'(error_inst_in_if), 32'd0);
        step();
        chk("t4_adef", 32'(if_adef), 32'd1);
        chk("t4_inst_zero", if_inst, 32'd0);
        chk("t4_valid", 32'(if_valid_out), 32'd1);
        chk("t4_pc", if_pc, 32'h1c00_0102);
        chk("t4_hold_no_req", 32'(inst_req), 32'd0);

        // 5: brstall holds fetch in REQ
        if_flush = 1'b1;
        flush_pc = 32'h1c00_0300;
        step();
        if_flush     = 1'b0;
        brstall      = 1'b1;
        inst_addr_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_no_req", 32'(inst_req), 32'd0);
            chk("t5_stall_pc", if_pc, 32'h1c00_0300);
            step();
        end
        brstall = 1'b0;
        #1;
        chk("t5_req_after", 32'(inst_req), 32'd1);
        chk("t5_addr_after", inst_addr, 32'h1c00_0300);
        step();
        inst_addr_ok = 1'b0;

        // 6: asynchronous reset in WAIT, stale data_ok afterwards
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_pc", if_pc, 32'h1c00_0000);
        chk("t6_req", 32'(inst_req), 32'd0);
        chk("t6_inst", if_inst, 32'd0);
        chk("t6_valid", 32'(if_valid_out), 32'd0);
        step();
        step();
        resetn       = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0bad_0bad;
        step();
        inst_data_ok = 1'b0;
        #1;
        chk("t6_stale_ignored", if_inst, 32'd0);
        chk("t6_stale_no_ready", 32'(if_ready_go), 32'd0);
        chk("t6_req", 32'(inst_req), 32'd1);
        chk("t6_addr", inst_addr, 32'h1c00_0000);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0340_0000;
        step();
        inst_data_ok = 1'b0;
        chk("t6_inst_live", if_inst, 32'h0340_0000);
        chk("t6_valid_live", 32'(if_valid_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
